// File: rtl/phase_gen.sv
// phase_gen: multi-cycle processor phase sequencer (F -> R -> X -> [M] -> W).
// Latency: 4 cycles per instruction (skip_m=1) or 5 cycles, plus one cycle per mem_wait stall in F/M.
// Backpressure: mem_wait holds the sequencer in F or M; everywhere else it is ignored.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   run       in   start/continue, sampled in IDLE and W
//   mem_wait  in   memory not ready, stalls F and M
//   halt      in   decoded halt, sampled in X
//   skip_m    in   instruction has no memory phase, sampled in X
//   wb_en     in   instruction writes the register file, sampled in W
//   phase     out  one-hot phase {f,r,x,m,w}; zero in IDLE and HALT
//   ir_we     out  instruction register load, last F cycle only
//   we        out  register file write enable, W & wb_en
//   pc_we     out  program counter update, once per retired instruction
//   halted    out  sequencer stopped by a halt instruction
//   retired   out  count of completed instructions (wraps at 16 bits)

module phase_gen (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic        mem_wait,
   input  logic        halt,
   input  logic        skip_m,
   input  logic        wb_en,
   output logic [4:0]  phase,
   output logic        ir_we,
   output logic        we,
   output logic        pc_we,
   output logic        halted,
   output logic [15:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_F    = 3'd1,
      S_R    = 3'd2,
      S_X    = 3'd3,
      S_M    = 3'd4,
      S_W    = 3'd5,
      S_HALT = 3'd6
   } state_t;

   // One-hot phase encodings
   localparam logic [4:0] PH_NONE = 5'b00000;
   localparam logic [4:0] PH_F    = 5'b10000;
   localparam logic [4:0] PH_R    = 5'b01000;
   localparam logic [4:0] PH_X    = 5'b00100;
   localparam logic [4:0] PH_M    = 5'b00010;
   localparam logic [4:0] PH_W    = 5'b00001;

   state_t      r_state;
   logic [4:0]  r_phase;
   logic        r_halted;
   logic [15:0] r_retired;

   logic        w_in_f;
   logic        w_in_w;

   // State, phase and halted are all registered together so phase is a
   // clean one-hot copy of the state with no decode glitches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_phase   <= PH_NONE;
         r_halted  <= 1'b0;
         r_retired <= 16'h0000;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (run) begin
                  r_state <= S_F;
                  r_phase <= PH_F;
               end
            end

            S_F: begin
               // Fetch completes on the first cycle memory is ready
               if (!mem_wait) begin
                  r_state <= S_R;
                  r_phase <= PH_R;
               end
            end

            S_R: begin
               r_state <= S_X;
               r_phase <= PH_X;
            end

            S_X: begin
               // Halt wins over skip_m: a halting instruction never reaches W,
               // so it produces no pc_we/we strobe and is not counted.
               if (halt) begin
                  r_state  <= S_HALT;
                  r_phase  <= PH_NONE;
                  r_halted <= 1'b1;
               end else if (skip_m) begin
                  r_state <= S_W;
                  r_phase <= PH_W;
               end else begin
                  r_state <= S_M;
                  r_phase <= PH_M;
               end
            end

            S_M: begin
               if (!mem_wait) begin
                  r_state <= S_W;
                  r_phase <= PH_W;
               end
            end

            S_W: begin
               // Every exit from W retires exactly one instruction
               r_retired <= r_retired + 16'd1;
               if (run) begin
                  r_state <= S_F;
                  r_phase <= PH_F;
               end else begin
                  r_state <= S_IDLE;
                  r_phase <= PH_NONE;
               end
            end

            S_HALT: begin
               // Only reset leaves HALT
               r_state  <= S_HALT;
               r_phase  <= PH_NONE;
               r_halted <= 1'b1;
            end

            default: begin
               r_state  <= S_IDLE;
               r_phase  <= PH_NONE;
               r_halted <= 1'b0;
            end
         endcase
      end
   end

   assign w_in_f = r_phase[4];
   assign w_in_w = r_phase[0];

   // ir_we is combinational on mem_wait so it fires in the single F cycle
   // that actually captures the instruction.
   assign ir_we   = w_in_f & ~mem_wait;
   assign we      = w_in_w & wb_en;
   assign pc_we   = w_in_w;
   assign phase   = r_phase;
   assign halted  = r_halted;
   assign retired = r_retired;

endmodule

// File: tb/tb_phase_gen.sv
module tb_phase_gen;

   logic        clk;
   logic        rst;
   logic        run;
   logic        mem_wait;
   logic        halt;
   logic        skip_m;
   logic        wb_en;
   logic [4:0]  phase;
   logic        ir_we;
   logic        we;
   logic        pc_we;
   logic        halted;
   logic [15:0] retired;

   int total;
   int bad;

   phase_gen dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .mem_wait (mem_wait),
      .halt     (halt),
      .skip_m   (skip_m),
      .wb_en    (wb_en),
      .phase    (phase),
      .ir_we    (ir_we),
      .we       (we),
      .pc_we    (pc_we),
      .halted   (halted),
      .retired  (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Absolute time bound for the whole run
   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   // Synchronous-style reset pulse; leaves the DUT in IDLE shortly after a negedge
   task automatic do_reset();
      rst      = 1'b1;
      run      = 1'b0;
      mem_wait = 1'b0;
      halt     = 1'b0;
      skip_m   = 1'b0;
      wb_en    = 1'b0;
      @(negedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b1;
      #1;
      total++;
      if (phase !== 5'b00000) begin
         bad++; $display("FAIL reset_phase: got %b want %b", phase, 5'b00000);
      end
      total++;
      if (retired !== 16'h0000) begin
         bad++; $display("FAIL reset_retired: got %h want %h", retired, 16'h0000);
      end
      total++;
      if ({halted, ir_we, we, pc_we} !== 4'b0000) begin
         bad++; $display("FAIL reset_strobes: got %b want %b", {halted, ir_we, we, pc_we}, 4'b0000);
      end
      rst = 1'b0;
      @(negedge clk);
      #1;
      total++;
      if (phase !== 5'b00000) begin
         bad++; $display("FAIL reset_idle_stays: got %b want %b", phase, 5'b00000);
      end
   endtask

   task automatic test_basic();
      logic [4:0] seq [5];
      seq[0] = 5'b10000; seq[1] = 5'b01000; seq[2] = 5'b00100;
      seq[3] = 5'b00010; seq[4] = 5'b00001;
      do_reset();
      run    = 1'b1;
      skip_m = 1'b0;
      wb_en  = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         #1;
         total++;
         if (phase !== seq[i % 5]) begin
            bad++; $display("FAIL basic_phase[%0d]: got %b want %b", i, phase, seq[i % 5]);
         end
         total++;
         if (pc_we !== ((i % 5) == 4)) begin
            bad++; $display("FAIL basic_pc_we[%0d]: got %b want %b", i, pc_we, ((i % 5) == 4));
         end
         total++;
         if (ir_we !== ((i % 5) == 0)) begin
            bad++; $display("FAIL basic_ir_we[%0d]: got %b want %b", i, ir_we, ((i % 5) == 0));
         end
         total++;
         if (retired !== 16'(i / 5)) begin
            bad++; $display("FAIL basic_retired[%0d]: got %0d want %0d", i, retired, i / 5);
         end
      end
      @(negedge clk);
      #1;
      total++;
      if (retired !== 16'd3) begin
         bad++; $display("FAIL basic_retired_final: got %0d want 3", retired);
      end
      total++;
      if (phase !== 5'b10000) begin
         bad++; $display("FAIL basic_back_to_back: got %b want %b", phase, 5'b10000);
      end
   endtask

   task automatic test_skip();
      logic [4:0] seq [4];
      seq[0] = 5'b10000; seq[1] = 5'b01000; seq[2] = 5'b00100; seq[3] = 5'b00001;
      do_reset();
      run    = 1'b1;
      skip_m = 1'b1;
      wb_en  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         if (i == 3) run = 1'b0;
         total++;
         if (phase !== seq[i]) begin
            bad++; $display("FAIL skip_phase[%0d]: got %b want %b", i, phase, seq[i]);
         end
      end
      total++;
      if (retired !== 16'd0) begin
         bad++; $display("FAIL skip_retired_in_w: got %0d want 0", retired);
      end
      @(negedge clk);
      #1;
      total++;
      if (phase !== 5'b00000) begin
         bad++; $display("FAIL skip_to_idle: got %b want %b", phase, 5'b00000);
      end
      total++;
      if (retired !== 16'd1) begin
         bad++; $display("FAIL skip_retired: got %0d want 1", retired);
      end
   endtask

   task automatic test_stall();
      do_reset();
      run      = 1'b1;
      skip_m   = 1'b0;
      wb_en    = 1'b1;
      mem_wait = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         mem_wait = (i < 3);
         #1;
         total++;
         if (phase !== 5'b10000) begin
            bad++; $display("FAIL stall_f_phase[%0d]: got %b want %b", i, phase, 5'b10000);
         end
         total++;
         if (ir_we !== (i == 3)) begin
            bad++; $display("FAIL stall_f_ir_we[%0d]: got %b want %b", i, ir_we, (i == 3));
         end
      end
      // mem_wait in R and X must not stall
      @(negedge clk);
      #1;
      mem_wait = 1'b1;
      #1;
      total++;
      if (phase !== 5'b01000 || ir_we !== 1'b0) begin
         bad++; $display("FAIL stall_r: got %b/%b want %b/0", phase, ir_we, 5'b01000);
      end
      @(negedge clk);
      #1;
      total++;
      if (phase !== 5'b00100) begin
         bad++; $display("FAIL stall_x: got %b want %b", phase, 5'b00100);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         mem_wait = (i < 3);
         #1;
         total++;
         if (phase !== 5'b00010) begin
            bad++; $display("FAIL stall_m_phase[%0d]: got %b want %b", i, phase, 5'b00010);
         end
         total++;
         if ({pc_we, we} !== 2'b00) begin
            bad++; $display("FAIL stall_m_strobes[%0d]: got %b want 00", i, {pc_we, we});
         end
      end
      @(negedge clk);
      #1;
      run = 1'b0;
      total++;
      if (phase !== 5'b00001 || pc_we !== 1'b1 || we !== 1'b1) begin
         bad++; $display("FAIL stall_w: got %b pc_we=%b we=%b want %b pc_we=1 we=1", phase, pc_we, we, 5'b00001);
      end
      @(negedge clk);
      #1;
      total++;
      if (phase !== 5'b00000 || retired !== 16'd1) begin
         bad++; $display("FAIL stall_done: got %b retired=%0d want %b retired=1", phase, retired, 5'b00000);
      end
   endtask

   task automatic test_halt();
      do_reset();
      run    = 1'b1;
      wb_en  = 1'b1;
      skip_m = 1'b1;
      halt   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
      end
      total++;
      if (phase !== 5'b00100) begin
         bad++; $display("FAIL halt_in_x: got %b want %b", phase, 5'b00100);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         run = i[0];
         #1;
         total++;
         if (phase !== 5'b00000 || halted !== 1'b1) begin
            bad++; $display("FAIL halt_hold[%0d]: got %b halted=%b want 00000 halted=1", i, phase, halted);
         end
         total++;
         if ({pc_we, we, ir_we} !== 3'b000 || retired !== 16'd0) begin
            bad++; $display("FAIL halt_strobes[%0d]: got %b retired=%0d want 000 retired=0", i, {pc_we, we, ir_we}, retired);
         end
      end
      rst = 1'b1;
      #1;
      total++;
      if (halted !== 1'b0) begin
         bad++; $display("FAIL halt_cleared: got %b want 0", halted);
      end
      rst  = 1'b0;
      halt = 1'b0;
   endtask

   task automatic test_async_reset();
      do_reset();
      run    = 1'b1;
      skip_m = 1'b0;
      wb_en  = 1'b1;
      // One full instruction, then F, R, X of the next
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         #1;
      end
      mem_wait = 1'b1;
      @(negedge clk);
      #1;
      total++;
      if (phase !== 5'b00010 || retired !== 16'd1) begin
         bad++; $display("FAIL arst_pre: got %b retired=%0d want 00010 retired=1", phase, retired);
      end
      #1;
      rst = 1'b1;
      #1;
      total++;
      if (phase !== 5'b00000 || retired !== 16'd0) begin
         bad++; $display("FAIL arst_async: got %b retired=%0d want 00000 retired=0", phase, retired);
      end
      total++;
      if ({ir_we, we, pc_we, halted} !== 4'b0000) begin
         bad++; $display("FAIL arst_strobes: got %b want 0000", {ir_we, we, pc_we, halted});
      end
      rst      = 1'b0;
      mem_wait = 1'b0;
      @(negedge clk);
      #1;
      total++;
      if (phase !== 5'b10000) begin
         bad++; $display("FAIL arst_restart: got %b want %b", phase, 5'b10000);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      run    = 1'b1;
      skip_m = 1'b1;
      wb_en  = 1'b0;
      @(negedge clk);
      #1;
      // Shortcut for 65535 prior retirements
      force dut.r_retired = 16'hFFFF;
      #1;
      release dut.r_retired;
      @(negedge clk);
      #1;
      @(negedge clk);
      #1;
      @(negedge clk);
      #1;
      run = 1'b0;
      total++;
      if (phase !== 5'b00001 || pc_we !== 1'b1 || we !== 1'b0) begin
         bad++; $display("FAIL wrap_w: got %b pc_we=%b we=%b want 00001 pc_we=1 we=0", phase, pc_we, we);
      end
      total++;
      if (retired !== 16'hFFFF) begin
         bad++; $display("FAIL wrap_pre: got %h want ffff", retired);
      end
      @(negedge clk);
      #1;
      total++;
      if (retired !== 16'h0000) begin
         bad++; $display("FAIL wrap_post: got %h want 0000", retired);
      end
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      rst      = 1'b1;
      run      = 1'b0;
      mem_wait = 1'b0;
      halt     = 1'b0;
      skip_m   = 1'b0;
      wb_en    = 1'b0;
      test_reset();
      test_basic();
      test_skip();
      test_stall();
      test_halt();
      test_async_reset();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/phase_gen.md
PHASE_GEN -- requirements
Module: phase_gen

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port run  input  1  start/continue; sampled in IDLE and W.
REQ-004 SHALL have port mem_wait  input  1  memory not ready; stalls F and M.
REQ-005 SHALL have port halt  input  1  decoded halt instruction; sampled in X only.
REQ-006 SHALL have port skip_m  input  1  instruction has no memory access; sampled in X only.
REQ-007 SHALL have port wb_en  input  1  instruction writes register file; sampled in W only.
REQ-008 SHALL have port phase  output  5  one-hot phase: bit4=f, bit3=r, bit2=x, bit1=m, bit0=w.
REQ-009 SHALL have port ir_we  output  1  instruction register load strobe.
REQ-010 SHALL have port we  output  1  register file write enable.
REQ-011 SHALL have port pc_we  output  1  program counter update strobe.
REQ-012 SHALL have port halted  output  1  processor stopped by halt.
REQ-013 SHALL have port retired  output  16  count of completed instructions.

Function
REQ-014 SHALL implement states IDLE, F, R, X, M, W, HALT.
REQ-015 SHALL drive phase = 5'b00000 in IDLE and HALT, and exactly one bit set in F/R/X/M/W.
REQ-016 IDLE SHALL go to F when run=1, else stay in IDLE.
REQ-017 F SHALL stay in F while mem_wait=1, else go to R.
REQ-018 R SHALL go to X unconditionally after one cycle.
REQ-019 X SHALL go to HALT if halt=1; else to W if skip_m=1; else to M; halt takes priority over skip_m.
REQ-020 M SHALL stay in M while mem_wait=1, else go to W.
REQ-021 W SHALL last one cycle and then go to F if run=1, else to IDLE.
REQ-022 HALT SHALL be held until rst; run is ignored.
REQ-023 ir_we SHALL be 1 only in F with mem_wait=0 (combinational), i.e. exactly one cycle per fetch.
REQ-024 we SHALL equal (state==W) & wb_en; it SHALL never be 1 outside W.
REQ-025 pc_we SHALL be 1 only in W, one cycle per instruction, irrespective of wb_en; it SHALL be 0 for a halting instruction.
REQ-026 halted SHALL be 1 exactly when state==HALT.
REQ-027 retired SHALL increment by 1 on each clock edge leaving W, and SHALL wrap from 16'hFFFF to 16'h0000.
REQ-028 Minimum instruction latency SHALL be 4 cycles (F,R,X,W) with skip_m=1, or 5 cycles (F,R,X,M,W) otherwise, plus one cycle per mem_wait stall cycle.
REQ-029 mem_wait in R, X, W, IDLE or HALT SHALL have no effect.

Reset
REQ-030 rst=1 SHALL immediately, without a clock edge, force state=IDLE, phase=0, retired=0, halted=0, and ir_we=we=pc_we=0.
REQ-031 rst asserted in any state, including mid-stall or HALT, SHALL abort the instruction with no further strobes; after release, operation SHALL restart from IDLE.

Verification
REQ-032 Reset then run=1, skip_m=0, mem_wait=0 -> phase sequence 10000,01000,00100,00010,00001, repeating; pc_we once per 5 cycles; retired=3 after 15 cycles.
REQ-033 skip_m=1 in X -> phase 00100 is followed directly by 00001; 4-cycle instruction; retired increments once.
REQ-034 mem_wait=1 for 3 cycles in F -> phase holds at 10000 for 4 cycles; ir_we=1 only in the final F cycle; same check for M at 00010.
REQ-035 halt=1 and skip_m=1 in X -> next phase=00000, halted=1, pc_we/we never asserted, retired unchanged; run toggling keeps halted=1 until rst.
REQ-036 rst pulsed asynchronously between clock edges during M with mem_wait=1 -> phase=00000 and retired=0 before the next edge; run=1 afterward restarts at 10000.
REQ-037 Preload retired=16'hFFFF (by running 65535 instructions) -> next retirement gives 16'h0000; wb_en=0 in W -> we=0 while pc_we=1.
